// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the dcache request-port arbiter: FSM states, dcache command
// codes, request payload and exception bundles.
package dmem_port_arbiter_pkg;

  localparam int DMEM_ADDR_W = 40;
  localparam int DMEM_DATA_W = 64;
  localparam int DMEM_TAG_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [4:0] M_XRD    = 5'b00000;
  localparam logic [4:0] M_XWR    = 5'b00001;
  localparam logic [4:0] M_PFR    = 5'b00010;
  localparam logic [4:0] M_PFW    = 5'b00011;
  localparam logic [4:0] M_XA_ADD = 5'b01000;
  localparam logic [4:0] M_XLR    = 5'b00110;
  localparam logic [4:0] M_XSC    = 5'b00111;

  typedef struct packed {
    logic [4:0]             cmd;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [3:0]             op_type;
    logic [DMEM_DATA_W-1:0] data;
    logic [DMEM_TAG_W-1:0]  tag;
  } dmem_req_t;

  typedef struct packed {
    logic ma_st;
    logic ma_ld;
    logic pf_st;
    logic pf_ld;
  } dmem_xcpt_t;

  function automatic logic [1:0] owner_onehot(input logic idx);
    if (idx) begin
      return 2'b10;
    end else begin
      return 2'b01;
    end
  endfunction

  // Place a 4-bit exception bundle into the owner's nibble of the routed bus.
  function automatic logic [7:0] route_xcpt(input logic idx, input dmem_xcpt_t x);
    if (idx) begin
      return {x, 4'b0000};
    end else begin
      return {4'b0000, x};
    end
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the requester-side and dcache-side buses of the port arbiter.
// slave is the arbiter's view, master is the environment's view.
interface dmem_port_arbiter_if
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W,
  parameter int TAG_W  = DMEM_TAG_W
);
  logic [1:0]          req_valid_i;
  logic [1:0]          req_ready_o;
  logic [9:0]          req_cmd_i;
  logic [2*ADDR_W-1:0] req_addr_i;
  logic [7:0]          req_op_type_i;
  logic [2*DATA_W-1:0] req_data_i;
  logic [2*TAG_W-1:0]  req_tag_i;
  logic [1:0]          req_kill_i;
  logic [1:0]          resp_valid_o;
  logic [1:0]          resp_nack_o;
  logic [DATA_W-1:0]   resp_data_o;
  logic [7:0]          resp_xcpt_o;
  logic                timeout_o;
  logic                dmem_req_valid_o;
  logic                dmem_req_ready_i;
  logic [4:0]          dmem_req_cmd_o;
  logic [ADDR_W-1:0]   dmem_req_addr_o;
  logic [3:0]          dmem_op_type_o;
  logic [DATA_W-1:0]   dmem_req_data_o;
  logic [TAG_W-1:0]    dmem_req_tag_o;
  logic                dmem_req_kill_o;
  logic                dmem_resp_valid_i;
  logic                dmem_resp_nack_i;
  logic [DATA_W-1:0]   dmem_resp_data_i;
  logic                dmem_xcpt_ma_st_i;
  logic                dmem_xcpt_ma_ld_i;
  logic                dmem_xcpt_pf_st_i;
  logic                dmem_xcpt_pf_ld_i;

  modport slave (
    input  req_valid_i, req_cmd_i, req_addr_i, req_op_type_i, req_data_i, req_tag_i, req_kill_i,
    output req_ready_o, resp_valid_o, resp_nack_o, resp_data_o, resp_xcpt_o, timeout_o,
    output dmem_req_valid_o, dmem_req_cmd_o, dmem_req_addr_o, dmem_op_type_o,
    output dmem_req_data_o, dmem_req_tag_o, dmem_req_kill_o,
    input  dmem_req_ready_i, dmem_resp_valid_i, dmem_resp_nack_i, dmem_resp_data_i,
    input  dmem_xcpt_ma_st_i, dmem_xcpt_ma_ld_i, dmem_xcpt_pf_st_i, dmem_xcpt_pf_ld_i
  );

  modport master (
    output req_valid_i, req_cmd_i, req_addr_i, req_op_type_i, req_data_i, req_tag_i, req_kill_i,
    input  req_ready_o, resp_valid_o, resp_nack_o, resp_data_o, resp_xcpt_o, timeout_o,
    input  dmem_req_valid_o, dmem_req_cmd_o, dmem_req_addr_o, dmem_op_type_o,
    input  dmem_req_data_o, dmem_req_tag_o, dmem_req_kill_o,
    output dmem_req_ready_i, dmem_resp_valid_i, dmem_resp_nack_i, dmem_resp_data_i,
    output dmem_xcpt_ma_st_i, dmem_xcpt_ma_ld_i, dmem_xcpt_pf_st_i, dmem_xcpt_pf_ld_i
  );

endinterface

// File: rtl/dmem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter. A tie goes to the requester that did not win
// last; last_grant only moves when a grant is actually issued.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  logic last_grant_r;
  logic idx_s;

  // Winner selection and gated one-hot grant.
  always_comb begin
    if (req == 2'b11) begin
      idx_s = ~last_grant_r;
    end else if (req[1]) begin
      idx_s = 1'b1;
    end else begin
      idx_s = 1'b0;
    end
    if (en && (req != 2'b00)) begin
      gnt = idx_s ? 2'b10 : 2'b01;
    end else begin
      gnt = 2'b00;
    end
  end

  assign gnt_idx = idx_s;

  // Remember the last winner; reset to 1 so requester 0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= 1'b1;
    end else if (en && (req != 2'b00)) begin
      last_grant_r <= idx_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single L1 dcache request port between the scalar and vector
// front-ends, sequencing one transaction at a time and routing results back.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int TAG_W   = DMEM_TAG_W,
  parameter int TIMEOUT = 1024
) (
  input logic              clk_i,
  input logic              rstn_i,
  dmem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  state_t           state_r;
  dmem_req_t        req_r;
  logic             owner_r;
  logic [CNT_W-1:0] wait_cnt_r;
  logic [7:0]       xcpt_r;

  dmem_req_t  pick_s;
  dmem_xcpt_t xcpt_in_s;
  logic [1:0] gnt_s;
  logic       gnt_idx_s;
  logic       grant_en_s;
  logic       busy_s;
  logic       kill_s;
  logic       xcpt_hit_s;
  logic       resp_hit_s;
  logic       nack_hit_s;
  logic       tmo_hit_s;
  logic       abort_s;

  rr_arbiter2 u_rr_arbiter2 (
    .clk     (clk_i),
    .rst_n   (rstn_i),
    .req     (bus.req_valid_i),
    .en      (grant_en_s),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  assign xcpt_in_s = {bus.dmem_xcpt_ma_st_i, bus.dmem_xcpt_ma_ld_i,
                      bus.dmem_xcpt_pf_st_i, bus.dmem_xcpt_pf_ld_i};

  // Payload of the winning requester; tag bit 0 carries the owner index.
  always_comb begin
    if (gnt_idx_s) begin
      pick_s.cmd     = bus.req_cmd_i[9:5];
      pick_s.addr    = bus.req_addr_i[2*ADDR_W-1:ADDR_W];
      pick_s.op_type = bus.req_op_type_i[7:4];
      pick_s.data    = bus.req_data_i[2*DATA_W-1:DATA_W];
      pick_s.tag     = {bus.req_tag_i[2*TAG_W-1:TAG_W+1], 1'b1};
    end else begin
      pick_s.cmd     = bus.req_cmd_i[4:0];
      pick_s.addr    = bus.req_addr_i[ADDR_W-1:0];
      pick_s.op_type = bus.req_op_type_i[3:0];
      pick_s.data    = bus.req_data_i[DATA_W-1:0];
      pick_s.tag     = {bus.req_tag_i[TAG_W-1:1], 1'b0};
    end
  end

  // Completion events in priority order: kill, exception, response, nack, watchdog.
  always_comb begin
    grant_en_s = (state_r == ST_IDLE);
    busy_s     = (state_r == ST_REQ) || (state_r == ST_WAIT);
    kill_s     = busy_s && bus.req_kill_i[owner_r];
    xcpt_hit_s = busy_s && !kill_s && (xcpt_in_s != 4'b0000);
    resp_hit_s = (state_r == ST_WAIT) && !kill_s && !xcpt_hit_s && bus.dmem_resp_valid_i;
    nack_hit_s = (state_r == ST_WAIT) && !kill_s && !xcpt_hit_s && !bus.dmem_resp_valid_i
                 && bus.dmem_resp_nack_i;
    tmo_hit_s  = (state_r == ST_WAIT) && !kill_s && !xcpt_hit_s && !bus.dmem_resp_valid_i
                 && !bus.dmem_resp_nack_i && (wait_cnt_r == CNT_W'(TIMEOUT - 1));
    abort_s    = kill_s || xcpt_hit_s || tmo_hit_s;
  end

  assign bus.req_ready_o      = gnt_s;
  assign bus.resp_valid_o     = resp_hit_s ? owner_onehot(owner_r) : 2'b00;
  assign bus.resp_nack_o      = nack_hit_s ? owner_onehot(owner_r) : 2'b00;
  assign bus.resp_data_o      = bus.dmem_resp_data_i;
  assign bus.resp_xcpt_o      = xcpt_r;
  assign bus.timeout_o        = tmo_hit_s;
  assign bus.dmem_req_valid_o = (state_r == ST_REQ) && !abort_s;
  assign bus.dmem_req_kill_o  = abort_s;
  assign bus.dmem_req_cmd_o   = req_r.cmd;
  assign bus.dmem_req_addr_o  = req_r.addr;
  assign bus.dmem_op_type_o   = req_r.op_type;
  assign bus.dmem_req_data_o  = req_r.data;
  assign bus.dmem_req_tag_o   = req_r.tag;

  // Transaction sequencer: grant capture, dcache handshake, completion, abort.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r    <= ST_IDLE;
      req_r      <= {$bits(dmem_req_t){1'b0}};
      owner_r    <= 1'b0;
      wait_cnt_r <= {CNT_W{1'b0}};
      xcpt_r     <= 8'h00;
    end else begin
      xcpt_r <= xcpt_hit_s ? route_xcpt(owner_r, xcpt_in_s) : 8'h00;
      case (state_r)
        ST_IDLE: begin
          if (gnt_s != 2'b00) begin
            state_r <= ST_REQ;
            owner_r <= gnt_idx_s;
            req_r   <= pick_s;
          end
        end
        ST_REQ: begin
          if (abort_s) begin
            state_r <= ST_IDLE;
          end else if (bus.dmem_req_ready_i) begin
            state_r    <= ST_WAIT;
            wait_cnt_r <= {CNT_W{1'b0}};
          end
        end
        ST_WAIT: begin
          if (abort_s || resp_hit_s || nack_hit_s) begin
            state_r <= ST_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomised bench for dmem_port_arbiter: the driver predicts every non-idle
// output cycle into a queue, an independent negedge monitor compares.
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam int TIMEOUT = 8;
  localparam int K_RESP = 0, K_NACK = 1, K_KILL_WAIT = 2, K_KILL_RESP = 3;
  localparam int K_XCPT_REQ = 4, K_XCPT_WAIT = 5, K_TMO = 6, K_KILL_REQ = 7;

  typedef struct packed {
    logic [1:0]   ready;
    logic         dvalid;
    logic [120:0] payload;
    logic [1:0]   rvalid;
    logic [1:0]   rnack;
    logic [63:0]  rdata;
    logic [7:0]   xcpt;
    logic         tmo;
    logic         kill;
  } obs_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  int   lg = 1;
  obs_t  exp_q[$];
  string lbl_q[$];
  obs_t  mon_o;
  obs_t  mon_e;
  string mon_l;

  logic [4:0]  cmd_v[2];
  logic [39:0] addr_v[2];
  logic [3:0]  op_v[2];
  logic [63:0] data_v[2];
  logic [7:0]  tag_v[2];
  logic [63:0] rdata_v;

  dmem_port_arbiter_if bus ();

  dmem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o = '0;
    o.ready  = bus.req_ready_o;
    o.dvalid = bus.dmem_req_valid_o;
    if (o.dvalid) o.payload = {bus.dmem_req_cmd_o, bus.dmem_req_addr_o, bus.dmem_op_type_o,
                               bus.dmem_req_data_o, bus.dmem_req_tag_o};
    o.rvalid = bus.resp_valid_o;
    o.rnack  = bus.resp_nack_o;
    if (o.rvalid != 2'b00) o.rdata = bus.resp_data_o;
    o.xcpt = bus.resp_xcpt_o;
    o.tmo  = bus.timeout_o;
    o.kill = bus.dmem_req_kill_o;
    return o;
  endfunction

  // Monitor: every cycle with any activity must match the next prediction.
  always @(negedge clk) begin
    mon_o = sample();
    if (mon_o !== '0) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected activity: got %h want nothing", mon_o);
      end else begin
        mon_e = exp_q.pop_front();
        mon_l = lbl_q.pop_front();
        if (mon_o !== mon_e) begin
          mismatched++;
          $display("FAIL %s: got %h want %h", mon_l, mon_o, mon_e);
        end
      end
    end
  end

  task automatic expect_obs(input obs_t e, input string l);
    exp_q.push_back(e);
    lbl_q.push_back(l);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.req_valid_i       = 2'b00;
    bus.req_kill_i        = 2'b00;
    bus.dmem_req_ready_i  = 1'b0;
    bus.dmem_resp_valid_i = 1'b0;
    bus.dmem_resp_nack_i  = 1'b0;
    bus.dmem_xcpt_ma_st_i = 1'b0;
    bus.dmem_xcpt_ma_ld_i = 1'b0;
    bus.dmem_xcpt_pf_st_i = 1'b0;
    bus.dmem_xcpt_pf_ld_i = 1'b0;
  endtask

  task automatic drive_payloads();
    bus.req_cmd_i     = {cmd_v[1], cmd_v[0]};
    bus.req_addr_i    = {addr_v[1], addr_v[0]};
    bus.req_op_type_i = {op_v[1], op_v[0]};
    bus.req_data_i    = {data_v[1], data_v[0]};
    bus.req_tag_i     = {tag_v[1], tag_v[0]};
  endtask

  task automatic rand_payloads();
    for (int n = 0; n < 2; n++) begin
      cmd_v[n]  = 5'($urandom_range(0, 31));
      addr_v[n] = 40'({$urandom, $urandom});
      op_v[n]   = 4'($urandom_range(0, 15));
      data_v[n] = {$urandom, $urandom};
      tag_v[n]  = 8'($urandom_range(0, 255));
    end
    rdata_v = {$urandom, $urandom};
  endtask

  // What the dcache should see: the owner's payload, tag bit 0 = owner index.
  function automatic logic [120:0] exp_payload(input int own);
    logic [7:0] t;
    t = tag_v[own];
    t[0] = own[0];
    return {cmd_v[own], addr_v[own], op_v[own], data_v[own], t};
  endfunction

  task automatic check_zero(input string l);
    obs_t o;
    logic [120:0] raw;
    o = sample();
    raw = {bus.dmem_req_cmd_o, bus.dmem_req_addr_o, bus.dmem_op_type_o,
           bus.dmem_req_data_o, bus.dmem_req_tag_o};
    compared++;
    if ((o !== '0) || (raw !== '0)) begin
      mismatched++;
      $display("FAIL %s: got %h / %h want all zero", l, o, raw);
    end
  endtask

  task automatic set_xcpt(input logic [3:0] xv);
    bus.dmem_xcpt_ma_st_i = xv[3];
    bus.dmem_xcpt_ma_ld_i = xv[2];
    bus.dmem_xcpt_pf_st_i = xv[1];
    bus.dmem_xcpt_pf_ld_i = xv[0];
  endtask

  // One full transaction from an IDLE cycle; returns at the first IDLE cycle after it.
  task automatic txn(input logic [1:0] vm, input int kind, input int nwait, input int d,
                     input logic [3:0] xv_in);
    obs_t e;
    int own;
    logic [3:0] xv;
    logic [1:0] oh;
    logic [120:0] p;
    string l;
    xv  = (xv_in != 4'h0) ? xv_in : 4'($urandom_range(1, 15));
    own = (vm == 2'b11) ? (1 - lg) : (vm[1] ? 1 : 0);
    lg  = own;
    oh  = 2'(1 << own);
    p   = exp_payload(own);
    drive_payloads();
    bus.req_valid_i = vm;
    bus.dmem_resp_valid_i = 1'($urandom_range(0, 1));
    e = '0; e.ready = oh; expect_obs(e, "grant");
    step();
    quiet();
    for (int i = 0; i <= nwait; i++) begin
      bus.dmem_req_ready_i = (i == nwait);
      bus.req_kill_i[1-own] = 1'($urandom_range(0, 1));
      e = '0;
      if (i == 0 && kind == K_KILL_REQ) begin
        bus.req_kill_i[own] = 1'b1;
        e.kill = 1'b1; expect_obs(e, "kill in REQ");
        step(); quiet(); return;
      end
      if (i == 0 && kind == K_XCPT_REQ) begin
        set_xcpt(xv);
        e.kill = 1'b1; expect_obs(e, "xcpt kill in REQ");
        step(); quiet();
        e = '0; e.xcpt = 8'(xv) << (4 * own); expect_obs(e, "xcpt route from REQ");
        step(); return;
      end
      e.dvalid = 1'b1; e.payload = p; expect_obs(e, "issue");
      step();
    end
    quiet();
    for (int w = 0; w < TIMEOUT; w++) begin
      bus.req_kill_i[1-own] = 1'($urandom_range(0, 1));
      bus.req_valid_i = 2'($urandom_range(0, 3));
      e = '0;
      if (kind == K_TMO && w == TIMEOUT - 1) begin
        e.tmo = 1'b1; e.kill = 1'b1; expect_obs(e, "timeout");
        step(); quiet(); return;
      end
      if (kind != K_TMO && w == d) begin
        l = "resp";
        case (kind)
          K_RESP: begin
            bus.dmem_resp_valid_i = 1'b1;
            bus.dmem_resp_nack_i  = 1'($urandom_range(0, 1));
            bus.dmem_resp_data_i  = rdata_v;
            e.rvalid = oh; e.rdata = rdata_v;
          end
          K_NACK: begin
            bus.dmem_resp_nack_i = 1'b1; e.rnack = oh; l = "nack";
          end
          K_KILL_WAIT: begin
            bus.req_kill_i[own] = 1'b1; e.kill = 1'b1; l = "kill in WAIT";
          end
          K_KILL_RESP: begin
            bus.req_kill_i[own] = 1'b1; bus.dmem_resp_valid_i = 1'b1;
            bus.dmem_resp_data_i = rdata_v; e.kill = 1'b1; l = "kill beats resp";
          end
          K_XCPT_WAIT: begin
            set_xcpt(xv); e.kill = 1'b1; l = "xcpt kill in WAIT";
          end
          default: begin
            l = "unknown kind";
          end
        endcase
        expect_obs(e, l);
        step(); quiet();
        if (kind == K_XCPT_WAIT) begin
          e = '0; e.xcpt = 8'(xv) << (4 * own); expect_obs(e, "xcpt route from WAIT");
          step();
        end
        return;
      end
      step();
    end
  endtask

  initial begin
    int kind;
    int d;
    obs_t e;
    quiet();
    rand_payloads();
    drive_payloads();
    bus.dmem_resp_data_i = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset outputs");
    rstn = 1'b1;
    step();

    // Directed: scalar load, response two cycles after accept.
    rand_payloads();
    cmd_v[0] = M_XRD; addr_v[0] = 40'h00_8000_0040; op_v[0] = 4'h3; tag_v[0] = 8'h0A;
    rdata_v = 64'h0000_0000_DEAD_BEEF;
    txn(2'b01, K_RESP, 0, 1, 4'h0);
    // Directed: four ties, each completed by a response.
    for (int k = 0; k < 4; k++) begin
      rand_payloads();
      txn(2'b11, K_RESP, k % 2, k, 4'h0);
    end
    rand_payloads(); txn(2'b10, K_NACK, 1, 2, 4'h0);
    rand_payloads(); txn(2'b10, K_RESP, 0, 0, 4'h0);
    rand_payloads(); txn(2'b01, K_KILL_RESP, 0, 1, 4'h0);
    rand_payloads(); txn(2'b10, K_XCPT_REQ, 0, 0, 4'b0001);
    rand_payloads(); txn(2'b01, K_TMO, 1, 0, 4'h0);
    rand_payloads(); txn(2'b11, K_RESP, 0, TIMEOUT - 1, 4'h0);

    for (int t = 0; t < 200; t++) begin
      rand_payloads();
      kind = $urandom_range(0, 7);
      d = (kind == K_RESP) ? $urandom_range(0, TIMEOUT - 1) : $urandom_range(0, TIMEOUT - 2);
      txn(2'($urandom_range(1, 3)), kind, $urandom_range(0, 2), d, 4'h0);
      if ($urandom_range(0, 3) == 0) begin
        quiet(); step();
      end
    end

    // Reset in the middle of WAIT: everything drops, no kill, arbiter forgets history.
    rand_payloads(); drive_payloads();
    bus.req_valid_i = 2'b10;
    e = '0; e.ready = 2'b10; expect_obs(e, "pre-reset grant");
    step(); quiet();
    bus.dmem_req_ready_i = 1'b1;
    e = '0; e.dvalid = 1'b1; e.payload = exp_payload(1); expect_obs(e, "pre-reset issue");
    step(); quiet();
    #2 rstn = 1'b0;
    #1 check_zero("reset mid-transaction");
    step(); step();
    rstn = 1'b1;
    lg = 1;
    step();
    rand_payloads(); txn(2'b11, K_RESP, 0, 0, 4'h0);
    quiet(); step(); step();

    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL expected events not seen: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
